// File: rtl/alu_pkg.sv
// Constants shared by the operand-fetch stage and the ALU:
// datapath widths and the ALU opcode encodings.
package alu_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// Register file with two combinational read ports and one write port.
// r0 always reads as zero, and writes to it are discarded.
module reg_file #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = alu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_en && wr_addr != '0) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = (rd_addr_a == '0) ? '0 : mem[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0) ? '0 : mem[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage in front of the ALU: resolves A/B from the register file,
// an immediate or the writeback bypass, stalls on pending destinations, and registers the bundle.
module alu_operand_stage #(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = alu_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic                  in_use_imm,
  input  logic [2:0]            in_aluop,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic                  in_rd_wen,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_A,
  output logic [DATA_WIDTH-1:0] out_B,
  output logic [2:0]            out_ALUop,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic                  out_rd_wen
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rf_a, rf_b;
  logic [DATA_WIDTH-1:0] opnd_a, opnd_b;
  logic [NREG-1:0]       pending, pending_nxt;
  logic                  bypass_a, bypass_b;
  logic                  hazard_a, hazard_b, hazard;
  logic                  accept;

  reg_file #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_reg_file (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_a (in_rs1),
    .rd_data_a (rf_a),
    .rd_addr_b (in_rs2),
    .rd_data_b (rf_b),
    .wr_en     (wb_en),
    .wr_addr   (wb_addr),
    .wr_data   (wb_data)
  );

  // A writeback arriving this cycle both forwards its value and resolves the hazard.
  assign bypass_a = wb_en && (wb_addr == in_rs1) && (in_rs1 != '0);
  assign bypass_b = wb_en && (wb_addr == in_rs2) && (in_rs2 != '0);

  assign hazard_a = (in_rs1 != '0) && pending[in_rs1] && !bypass_a;
  assign hazard_b = !in_use_imm && (in_rs2 != '0) && pending[in_rs2] && !bypass_b;
  assign hazard   = hazard_a || hazard_b;

  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign opnd_a = bypass_a ? wb_data : rf_a;
  assign opnd_b = in_use_imm ? in_imm : (bypass_b ? wb_data : rf_b);

  // Clear before set so an accept and writeback on the same register leave it pending.
  always_comb begin
    pending_nxt = pending;
    if (wb_en) pending_nxt[wb_addr] = 1'b0;
    if (accept && in_rd_wen && in_rd != '0) pending_nxt[in_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  // ---- output register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_A      <= '0;
      out_B      <= '0;
      out_ALUop  <= '0;
      out_rd     <= '0;
      out_rd_wen <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_A      <= opnd_a;
      out_B      <= opnd_b;
      out_ALUop  <= in_aluop;
      out_rd     <= in_rd;
      out_rd_wen <= in_rd_wen;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expectations.
module tb_alu_operand_stage;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_imm;
  logic        in_use_imm, in_rd_wen;
  logic [2:0]  in_aluop;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_A, out_B;
  logic [2:0]  out_ALUop;
  logic [4:0]  out_rd;
  logic        out_rd_wen;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_use_imm(in_use_imm),
    .in_aluop(in_aluop), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_A(out_A), .out_B(out_B), .out_ALUop(out_ALUop),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] rs1, input logic [4:0] rs2, input logic use_imm,
                        input logic [31:0] imm, input logic [2:0] op,
                        input logic [4:0] rd, input logic rd_wen);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_use_imm = use_imm;
    in_imm = imm; in_aluop = op; in_rd = rd; in_rd_wen = rd_wen;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    wb_en = en; wb_addr = addr; wb_data = data;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
    in_use_imm = 1'b0; in_rd_wen = 1'b0; in_aluop = '0;
    set_wb(1'b0, 5'd0, 32'h0);
    step(); step();
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_A", out_A, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // Cleared array after reset
    set_op(5'd5, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    step(); in_valid = 1'b0;
    check("rst_issue_valid", {31'b0, out_valid}, 32'h1);
    check("rst_issue_A", out_A, 32'h0);
    check("rst_issue_B", out_B, 32'h0);
    check("rst_issue_op", {29'b0, out_ALUop}, {29'b0, ALU_ADD});

    // Writeback then read next cycle
    set_wb(1'b1, 5'd3, 32'h5);
    step(); set_wb(1'b0, 5'd0, 32'h0);
    set_op(5'd3, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    step(); in_valid = 1'b0;
    check("wbr_A", out_A, 32'h5);
    check("wbr_B", out_B, 32'h0);
    check("wbr_op", {29'b0, out_ALUop}, 32'h2);

    // Same-cycle bypass, immediate for B
    set_wb(1'b1, 5'd7, 32'hDEADBEEF);
    set_op(5'd7, 5'd0, 1'b1, 32'h1, ALU_OR, 5'd0, 1'b0);
    step(); in_valid = 1'b0; set_wb(1'b0, 5'd0, 32'h0);
    check("byp_A", out_A, 32'hDEADBEEF);
    check("byp_B", out_B, 32'h1);
    check("byp_op", {29'b0, out_ALUop}, 32'h1);
    set_op(5'd7, 5'd7, 1'b0, 32'h0, ALU_AND, 5'd0, 1'b0);
    step(); in_valid = 1'b0;
    check("arr_A", out_A, 32'hDEADBEEF);
    check("arr_B", out_B, 32'hDEADBEEF);

    // RAW stall on r4
    set_op(5'd0, 5'd0, 1'b0, 32'h0, ALU_SUB, 5'd4, 1'b1);
    step();
    check("raw_rd", {27'b0, out_rd}, 32'h4);
    check("raw_rd_wen", {31'b0, out_rd_wen}, 32'h1);
    set_op(5'd4, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("raw_stall_ready", {31'b0, in_ready}, 32'h0);
      step();
      check("raw_stall_drained", {31'b0, out_valid}, 32'h0);
    end
    set_wb(1'b1, 5'd4, 32'h10);
    #1;
    check("raw_wb_ready", {31'b0, in_ready}, 32'h1);
    step(); set_wb(1'b0, 5'd0, 32'h0);
    check("raw_wb_valid", {31'b0, out_valid}, 32'h1);
    check("raw_wb_A", out_A, 32'h10);
    #1;
    check("raw_cleared_ready", {31'b0, in_ready}, 32'h1);
    step(); in_valid = 1'b0;
    check("raw_cleared_A", out_A, 32'h10);

    // Backpressure: held bundle frozen, including against a writeback to its source
    set_op(5'd3, 5'd7, 1'b0, 32'h0, ALU_SLT, 5'd5, 1'b1);
    step();
    out_ready = 1'b0;
    set_op(5'd7, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd6, 1'b1);
    set_wb(1'b1, 5'd3, 32'h99);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      step(); set_wb(1'b0, 5'd0, 32'h0);
      check("bp_valid", {31'b0, out_valid}, 32'h1);
      check("bp_A", out_A, 32'h5);
      check("bp_B", out_B, 32'hDEADBEEF);
      check("bp_op", {29'b0, out_ALUop}, 32'h7);
      check("bp_rd", {27'b0, out_rd}, 32'h5);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_drain_valid", {31'b0, out_valid}, 32'h0);

    // r0: writes dropped, rd=0 never pending
    set_wb(1'b1, 5'd0, 32'hFFFF);
    step(); set_wb(1'b0, 5'd0, 32'h0);
    set_op(5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b1);
    step();
    check("r0_A", out_A, 32'h0);
    set_op(5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    #1;
    check("r0_no_stall", {31'b0, in_ready}, 32'h1);
    step(); in_valid = 1'b0;
    check("r0_accepted", {31'b0, out_valid}, 32'h1);

    // Immediate masks a pending rs2 (r5 still pending)
    set_op(5'd0, 5'd5, 1'b1, 32'h3, ALU_ADD, 5'd0, 1'b0);
    #1;
    check("imm_masks_rs2", {31'b0, in_ready}, 32'h1);
    in_use_imm = 1'b0;
    #1;
    check("rs2_pending", {31'b0, in_ready}, 32'h0);
    in_valid = 1'b0;

    // Set wins over clear on r9
    set_op(5'd0, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd9, 1'b1);
    set_wb(1'b1, 5'd9, 32'h42);
    step(); set_wb(1'b0, 5'd0, 32'h0);
    set_op(5'd9, 5'd0, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    #1;
    check("setwins_stall", {31'b0, in_ready}, 32'h0);
    set_wb(1'b1, 5'd9, 32'h77);
    step(); set_wb(1'b0, 5'd0, 32'h0);
    in_valid = 1'b0;
    check("setwins_A", out_A, 32'h77);

    // Reset mid-stall drops the bundle and clears array and scoreboard
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; out_ready = 1'b1;
    check("midrst_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_A", out_A, 32'h0);
    set_op(5'd9, 5'd5, 1'b0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    #1;
    check("midrst_ready", {31'b0, in_ready}, 32'h1);
    step(); in_valid = 1'b0;
    check("midrst_A_cleared", out_A, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage that sits directly upstream of the ALU. It holds the 32-entry register file and accepts decoded ops over a valid/ready handshake. Per op it resolves A/B from registers, an immediate, or a same-cycle writeback bypass, and tracks outstanding destination registers in a scoreboard. It then presents a registered {A, B, ALUop} bundle to the ALU stage over a second valid/ready handshake.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/register width
- ADDR_WIDTH, 5, register index width (2^ADDR_WIDTH registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  upstream op valid
- in_ready  out  1  stage accepts op this cycle
- in_rs1  in  ADDR_WIDTH  source register for A
- in_rs2  in  ADDR_WIDTH  source register for B
- in_imm  in  DATA_WIDTH  immediate for B
- in_use_imm  in  1  1: B = in_imm; rs2 ignored
- in_aluop  in  3  ALU opcode, passed through unmodified
- in_rd  in  ADDR_WIDTH  destination register of op
- in_rd_wen  in  1  op will write in_rd
- wb_en  in  1  writeback strobe from result stage
- wb_addr  in  ADDR_WIDTH  writeback register
- wb_data  in  DATA_WIDTH  writeback value
- out_valid  out  1  operand bundle valid
- out_ready  in  1  ALU stage accepts bundle
- out_A, out_B  out  DATA_WIDTH  operands
- out_ALUop  out  3  opcode
- out_rd, out_rd_wen  out  ADDR_WIDTH, 1  destination passthrough

## Operation
- Register file: 2^ADDR_WIDTH × DATA_WIDTH, 2 combinational read ports, 1 write port (wb_*). r0 reads 0 always; writes to r0 dropped.
- Bypass: if wb_en && wb_addr == rsX && rsX != 0 in the accept cycle, the operand is wb_data, not the array value.
- Scoreboard: pending bit per register.
  - On accept with in_rd_wen && in_rd != 0: set pending[in_rd].
  - On wb_en: clear pending[wb_addr].
  - Same register set and cleared in one cycle: set wins.
  - pending[0] is constant 0.
- Hazard: (rs1 != 0 && pending[rs1] && !(wb_en && wb_addr == rs1)) or the same term for rs2 when !in_use_imm.
- in_ready = !hazard && (!out_valid || out_ready).
- Accept = in_valid && in_ready. On accept, the output register loads A, B, aluop, rd, rd_wen; out_valid ← 1.
- out_valid clears when out_ready && out_valid && no accept in the same cycle.
- Captured operands are frozen; later writebacks do not update a held bundle.
- ALUop codes are not interpreted: AND 000, OR 001, ADD 010, SUB 110, SLT 111.

## Timing
- Reset: on the clk edge with rst=1:
  - all registers and pending bits ← 0
  - out_valid, out_A, out_B, out_ALUop, out_rd, out_rd_wen ← 0
  - rst dominates any simultaneous accept or writeback
  - rst mid-stall drops the held bundle
- Latency: 1 cycle, accept edge → out_valid.
- Throughput: 1 op/cycle when out_ready=1 and there are no hazards.
- Handshake: out_* stable while out_valid && !out_ready. in_ready may depend combinationally on out_ready, wb_*, in_rs*, and in_use_imm. It does not depend on in_valid.
- Write-then-read: wb at cycle N is visible in the array from N+1 and via bypass in cycle N.

## Structure
- Shared package alu_pkg: DATA_WIDTH, ADDR_WIDTH, ALUop localparams (AND/OR/ADD/SUB/SLT). The ALU uses the same constants.
- Sub-module reg_file: 2R1W array with r0 forced to zero and synchronous reset clear.
- Scoreboard, bypass, hazard, and the output register live in the top module.

## Test plan
- Reset: assert rst 2 cycles → out_valid=0, out_A=0; issue rs1=5, rs2=0, ADD → out_A=0, out_B=0.
- Writeback then read: wb r3=0x00000005 at cycle N; accept rs1=3, rs2=0, aluop=010 at N+1 → out_A=0x5, out_B=0, out_ALUop=010 at N+2.
- Bypass: wb r7=0xDEADBEEF in the same cycle as accepting rs1=7, use_imm=1, imm=0x1 → out_A=0xDEADBEEF, out_B=0x1.
- RAW stall:
  - accept rd=4, rd_wen=1; next op rs1=4 → in_ready=0 for 3 cycles.
  - wb r4=0x10 → accepted that cycle, out_A=0x10; pending[4]=0 afterwards.
- Backpressure: out_ready=0 for 3 cycles with a bundle held → out_* unchanged and in_ready=0. out_ready=1 with in_valid=0 → out_valid=0 next cycle.
- r0 and set-wins:
  - wb r0=0xFFFF → read r0 gives 0; an op with rd=0, rd_wen=1 never stalls a later rs1=0.
  - accept rd=9 while wb r9 in the same cycle → pending[9]=1.
